snake_seq_ctrl: RTL and testbench

Sequencing controller for the eight-cell snake network (cells U1..U8, five dependency levels). It accepts one token at a time from upstream and fires each level's cells with a one-cycle `go` pulse. It collects per-cell `done` pulses and only advances to the next level once every cell in the current level has reported. When the final cell completes, it presents `out_valid` downstream. It sits between the token source and the snake datapath and owns all start/completion sequencing for it.

---
 rtl/snake_seq_pkg.sv | 24 ++
 rtl/snake_seq_wdog.sv | 28 ++
 rtl/snake_seq_ctrl.sv | 108 ++++++++++
 tb/tb_snake_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_seq_pkg.sv
// rtl/snake_seq_pkg.sv - shared states, sizes and level map for the snake sequencing controller
package snake_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GO    = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } seq_state_t;

    localparam int NUM_LEVELS = 5;
    localparam int NUM_CELLS  = 8;

    localparam logic [NUM_CELLS-1:0] LEVEL_MASK [0:NUM_LEVELS-1] = '{
        8'h01, 8'h06, 8'h18, 8'h60, 8'h80
    };

    // Levels beyond the last one map to no cells rather than indexing past the table.
    function automatic logic [NUM_CELLS-1:0] level_mask(input logic [2:0] lvl);
        return (lvl < 3'(NUM_LEVELS)) ? LEVEL_MASK[lvl] : '0;
    endfunction

endpackage

// File: rtl/snake_seq_wdog.sv
// rtl/snake_seq_wdog.sv - per-level watchdog counter; expired flags the last allowed stalled WAIT cycle
module snake_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/snake_seq_ctrl.sv
// rtl/snake_seq_ctrl.sv - level-by-level go/done sequencer for the eight-cell snake network
// Optional watchdog and ERR state compiled in with SNAKE_SEQ_WATCHDOG_EN.
module snake_seq_ctrl
    import snake_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    output logic [NUM_CELLS-1:0] cell_go,
    input  logic [NUM_CELLS-1:0] cell_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [2:0]           level,
    output logic                 error
);

    localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);

    seq_state_t           state;
    logic [NUM_CELLS-1:0] pending;
    logic [NUM_CELLS-1:0] pending_next;
    logic [NUM_CELLS-1:0] cur_mask;
    logic                 wd_expired;

    assign cur_mask     = level_mask(level);
    assign pending_next = pending & ~(cell_done & cur_mask);

    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = (state == S_DRAIN);

    // cell_go is loaded on entry to GO so the pulse coincides with the GO cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            level   <= '0;
            cell_go <= '0;
            pending <= '0;
        end else begin
            cell_go <= '0;
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        level   <= '0;
                        cell_go <= level_mask(3'd0);
                        state   <= S_GO;
                    end
                end
                S_GO: begin
                    pending <= cur_mask;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    pending <= pending_next;
                    if (pending_next == '0) begin
                        if (level == LAST_LEVEL) begin
                            state <= S_DRAIN;
                        end else begin
                            level   <= level + 3'd1;
                            cell_go <= level_mask(level + 3'd1);
                            state   <= S_GO;
                        end
                    end else if (wd_expired) begin
                        state <= S_ERR;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        level <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

`ifdef SNAKE_SEQ_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state == S_GO);
    assign wd_enable = (state == S_WAIT) && (pending_next != '0);

    snake_seq_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // ERR is left only through reset, so decoding it gives a sticky flag.
    assign error = (state == S_ERR);
`else
    assign wd_expired = 1'b0;
    assign error      = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_snake_seq_ctrl.sv
// tb/tb_snake_seq_ctrl.sv - scoreboard bench: expected go masks and results queued at token launch
module tb_snake_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] cell_go;
    logic [7:0] cell_done;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [2:0] level;
    logic       error;

    logic [7:0] resp_done = '0;
    logic [7:0] extra_done;
    logic [7:0] nd;
    int         dly [8];
    int         cnt [8];
    int         cyc = 0;
    int         acc_cyc = 0;
    int         tok_id = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    int         lat;
    logic [7:0] go_q [$];
    int         out_q [$];

    assign cell_done = resp_done | extra_done;

    snake_seq_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cell_go     (cell_go),
        .cell_done   (cell_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .level       (level),
        .error       (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - acc_cyc);
        end
    endtask

    // Cell model: each cell answers dly[i] cycles after its go pulse; 0 means never.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            resp_done = '0;
        end else begin
            nd = '0;
            for (int i = 0; i < 8; i++) begin
                if (cnt[i] == 1) nd[i] = 1'b1;
                if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
                if (cell_go[i]) cnt[i] = dly[i];
            end
            resp_done = nd;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && cell_go != 8'h00) begin
            if (go_q.size() == 0) chk("go_unexpected", cell_go, 8'h00);
            else chk("go_seq", cell_go, go_q.pop_front());
        end
        if (rst_n && out_valid && out_ready) begin
            chk("out_unexpected", out_q.size() != 0, 1);
            if (out_q.size() != 0) void'(out_q.pop_front());
        end
    end

    task automatic all_dly(input int v);
        for (int i = 0; i < 8; i++) dly[i] = v;
    endtask

    task automatic start_token(input bit hold);
        chk("start_ready_idle", start_ready, 1);
        go_q.push_back(8'h01);
        go_q.push_back(8'h06);
        go_q.push_back(8'h18);
        go_q.push_back(8'h60);
        go_q.push_back(8'h80);
        out_q.push_back(tok_id);
        tok_id++;
        acc_cyc = cyc;
        start_valid = 1'b1;
        @(negedge clk);
        if (!hold) start_valid = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc - acc_cyc < n) @(negedge clk);
    endtask

    task automatic wait_out(output int c);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        if (!out_valid) chk("out_timeout", 0, 1);
        c = cyc - acc_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_cell_go"}, cell_go, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        out_ready = 1'b0;
        extra_done = '0;
        all_dly(1);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All cells answer after one cycle: minimum latency and return to IDLE.
        out_ready = 1'b1;
        start_token(0);
        wait_out(lat);
        chk("lat_min", lat, 11);
        @(negedge clk);
        chk("idle_ready", start_ready, 1);
        chk("idle_busy", busy, 0);

        // U3 reports four cycles after U2: level 1 holds until it does.
        dly[2] = 5;
        start_token(0);
        goto_cycle(4);
        for (int k = 0; k < 5; k++) begin
            chk("l1_hold", level, 1);
            @(negedge clk);
        end
        chk("l2_after_u3", level, 2);
        wait_out(lat);
        chk("lat_slow_u3", lat, 15);
        @(negedge clk);

        // U4 and U5 report together: L3 GO follows immediately.
        all_dly(1);
        dly[3] = 3;
        dly[4] = 3;
        start_token(0);
        goto_cycle(8);
        chk("l2_wait", level, 2);
        @(negedge clk);
        chk("l3_go_mask", cell_go, 8'h60);
        chk("l3_level", level, 3);
        wait_out(lat);
        chk("lat_joint_l2", lat, 13);
        @(negedge clk);

        // Stray U8 done in L0 and duplicate U2 done in L1 are ignored.
        all_dly(1);
        dly[0] = 3;
        dly[2] = 3;
        start_token(0);
        goto_cycle(2);
        extra_done = 8'h80;
        @(negedge clk);
        extra_done = '0;
        chk("stray_no_skip", level, 0);
        goto_cycle(7);
        extra_done = 8'h02;
        @(negedge clk);
        extra_done = '0;
        chk("dup_no_advance", level, 1);
        wait_out(lat);
        chk("lat_stray", lat, 15);
        @(negedge clk);

        // Downstream stalls five cycles with a new token already offered.
        all_dly(1);
        out_ready = 1'b0;
        start_token(1);
        wait_out(lat);
        chk("lat_stall", lat, 11);
        for (int k = 0; k < 5; k++) begin
            chk("drain_hold_valid", out_valid, 1);
            chk("drain_no_accept", start_ready, 0);
            @(negedge clk);
        end
        start_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_released", out_valid, 0);
        chk("drain_to_idle", start_ready, 1);

        // Reset during L2 WAIT aborts the token; the next one runs normally.
        start_token(0);
        goto_cycle(6);
        chk("pre_reset_level", level, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        go_q.delete();
        out_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_token(0);
        wait_out(lat);
        chk("lat_after_reset", lat, 11);
        @(negedge clk);

`ifdef SNAKE_SEQ_WATCHDOG_EN
        // U8 never reports: ERR after 15 stalled WAIT cycles, held until reset.
        dly[7] = 0;
        start_token(0);
        goto_cycle(24);
        chk("wd_not_yet", error, 0);
        @(negedge clk);
        chk("wd_tripped", error, 1);
        start_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("err_sticky", error, 1);
        chk("err_busy", busy, 1);
        chk("err_no_accept", start_ready, 0);
        chk("err_no_go", cell_go, 0);
        start_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("err_reset");
        go_q.delete();
        out_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        chk("go_queue_empty", go_q.size(), 0);
        chk("out_queue_empty", out_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
